// File: rtl/io_timer_bank.sv
// Bank of NCH up-counting timers on the J1 IO bus with auto-reload, one-shot mode,
// a shared prescaler and masked write-1-to-clear pending bits merged into one irq.
module io_timer_bank #(
    parameter int NCH   = 4,
    parameter int WIDTH = 16,
    parameter int PRE_W = 8
) (
    input  logic        clk,
    input  logic        resetq,
    input  logic        sel,
    input  logic        io_wr,
    input  logic [5:0]  io_addr,
    input  logic [15:0] io_dout,
    output logic [15:0] io_din,
    output logic        irq
);
    localparam logic [3:0] GCH = 4'(NCH);

    logic [3:0]       ch;
    logic [1:0]       r;
    logic             wr;
    logic [WIDTH-1:0] count  [NCH];
    logic [WIDTH-1:0] reload [NCH];
    logic [2:0]       ctrl   [NCH];
    logic [PRE_W-1:0] prescale;
    logic [PRE_W-1:0] pcnt;
    logic [NCH-1:0]   pending;
    logic [NCH-1:0]   irq_en;
    logic [NCH-1:0]   wr_ctrl, wr_rel, wr_cnt, step, ovf, w1c;
    logic             tick, wr_pre, wr_mask;
    logic             irq_p1;

    assign ch      = io_addr[5:2];
    assign r       = io_addr[1:0];
    assign wr      = sel & io_wr;
    assign tick    = (pcnt == prescale);
    assign wr_pre  = wr && (ch == GCH) && (r == 2'd0);
    assign wr_mask = wr && (ch == GCH) && (r == 2'd2);
    assign w1c     = (wr && (ch == GCH) && (r == 2'd1)) ? io_dout[NCH-1:0] : '0;
    assign irq     = irq_p1;

    // A CPU write to COUNT suppresses both the increment and the overflow of that cycle.
    always_comb begin
        wr_ctrl = '0;
        wr_rel  = '0;
        wr_cnt  = '0;
        step    = '0;
        ovf     = '0;
        for (int i = 0; i < NCH; i++) begin
            wr_ctrl[i] = wr && (ch == 4'(i)) && (r == 2'd0);
            wr_rel[i]  = wr && (ch == 4'(i)) && (r == 2'd1);
            wr_cnt[i]  = wr && (ch == 4'(i)) && (r == 2'd2);
            step[i]    = ctrl[i][0] && (!ctrl[i][2] || tick);
            ovf[i]     = step[i] && !wr_cnt[i] && (count[i] == '1);
        end
    end

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            for (int i = 0; i < NCH; i++) begin
                count[i]  <= '0;
                reload[i] <= '0;
                ctrl[i]   <= '0;
            end
            prescale <= '0;
            pcnt     <= '0;
            pending  <= '0;
            irq_en   <= '0;
            irq_p1   <= 1'b0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (wr_cnt[i])
                    count[i] <= io_dout[WIDTH-1:0];
                else if (step[i])
                    count[i] <= ovf[i] ? reload[i] : count[i] + 1'b1;
                if (wr_ctrl[i])
                    ctrl[i] <= io_dout[2:0];
                else if (ovf[i] && ctrl[i][1])
                    ctrl[i][0] <= 1'b0;
                if (wr_rel[i])
                    reload[i] <= io_dout[WIDTH-1:0];
            end
            // Overflow is OR-ed in after the clear so it wins over a simultaneous W1C.
            pending <= (pending & ~w1c) | ovf;
            if (wr_mask)
                irq_en <= io_dout[NCH-1:0];
            if (wr_pre) begin
                prescale <= io_dout[PRE_W-1:0];
                pcnt     <= '0;
            end else if (tick) begin
                pcnt <= '0;
            end else begin
                pcnt <= pcnt + 1'b1;
            end
            // irq stage: one cycle behind pending/mask
            irq_p1 <= |(pending & irq_en);
        end
    end

    always_comb begin
        io_din = '0;
        if (sel) begin
            for (int i = 0; i < NCH; i++) begin
                if (ch == 4'(i)) begin
                    case (r)
                        2'd0:    io_din = {13'd0, ctrl[i]};
                        2'd1:    io_din = 16'(reload[i]);
                        2'd2:    io_din = 16'(count[i]);
                        default: io_din = '0;
                    endcase
                end
            end
            if (ch == GCH) begin
                case (r)
                    2'd0:    io_din = 16'(prescale);
                    2'd1:    io_din = 16'(pending);
                    2'd2:    io_din = 16'(irq_en);
                    default: io_din = '0;
                endcase
            end
        end
    end
endmodule
